// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer: entry payload, drain FSM states,
// byte-lane merge and word-address compare.
package store_buffer_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned PORT_WIDTH = 32;
    localparam int unsigned PORT_BYTES = PORT_WIDTH / 8;

    typedef enum logic {
        IDLE,
        REQUEST
    } store_buffer_state_t;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] address;
        logic [PORT_WIDTH-1:0] data;
        logic [PORT_BYTES-1:0] byte_mask;
    } store_buffer_entry_t;

    // Byte offset bits are ignored when matching words.
    function automatic logic word_match(input logic [ADDR_WIDTH-1:0] a,
                                        input logic [ADDR_WIDTH-1:0] b);
        return ((a ^ b) & ~ADDR_WIDTH'(3)) == '0;
    endfunction

    function automatic logic [PORT_WIDTH-1:0] merge_bytes(input logic [PORT_WIDTH-1:0] old_data,
                                                          input logic [PORT_WIDTH-1:0] new_data,
                                                          input logic [PORT_BYTES-1:0] mask);
        logic [PORT_WIDTH-1:0] r;
        r = old_data;
        for (int unsigned b = 0; b < PORT_BYTES; b++) begin
            if (mask[b]) r[b*8 +: 8] = new_data[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/store_buffer_forward_unit.sv
// Combinational load-forwarding search: finds the youngest valid entry whose word
// address matches the load and reports a full or partial hit.
module store_buffer_forward_unit
    import store_buffer_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  store_buffer_entry_t    entries_i [DEPTH],
    input  logic [PTR_W-1:0]       head_i,
    input  logic [ADDR_WIDTH-1:0]  load_address_i,
    output logic                   address_match_o,
    output logic                   partial_match_o,
    output logic [PORT_WIDTH-1:0]  data_o
);

    logic                  hit;
    logic [PORT_WIDTH-1:0] hit_data;
    logic [PORT_BYTES-1:0] hit_mask;
    logic [PTR_W-1:0]      idx;

    // Walk oldest to youngest so the last hit found is the youngest one.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        hit_mask = '0;
        idx      = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_i + PTR_W'(k);
            if (entries_i[idx].valid && word_match(entries_i[idx].address, load_address_i)) begin
                hit      = 1'b1;
                hit_data = entries_i[idx].data;
                hit_mask = entries_i[idx].byte_mask;
            end
        end
    end

    assign address_match_o = hit && (&hit_mask);
    assign partial_match_o = hit && !(&hit_mask);
    assign data_o          = address_match_o ? hit_data : '0;

endmodule

// File: rtl/store_buffer.sv
// FIFO store buffer between cache controllers and external memory, with drain FSM
// and load forwarding. Define STORE_BUFFER_MERGE_EN to merge stores into the youngest entry.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ldu_push_i,
    input  logic [ADDR_WIDTH-1:0] ldu_address_i,
    input  logic [PORT_WIDTH-1:0] ldu_data_i,
    output logic                  ldu_push_ack_o,
    input  logic                  stu_push_i,
    input  logic [ADDR_WIDTH-1:0] stu_address_i,
    input  logic [PORT_WIDTH-1:0] stu_data_i,
    input  logic [PORT_BYTES-1:0] stu_byte_mask_i,
    output logic                  stu_push_ack_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  port_idle_o,
    input  logic [ADDR_WIDTH-1:0] load_address_i,
    output logic                  address_match_o,
    output logic                  partial_match_o,
    output logic [PORT_WIDTH-1:0] data_o,
    output logic                  external_write_request_o,
    output logic [ADDR_WIDTH-1:0] external_address_o,
    output logic [PORT_WIDTH-1:0] external_data_o,
    output logic [PORT_BYTES-1:0] external_byte_mask_o,
    input  logic                  external_acknowledge_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    store_buffer_entry_t entries_q [DEPTH];
    store_buffer_entry_t entries_d [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    store_buffer_state_t   state_q, state_d;
    logic [ADDR_WIDTH-1:0] ext_addr_q, ext_addr_d;
    logic [PORT_WIDTH-1:0] ext_data_q, ext_data_d;
    logic [PORT_BYTES-1:0] ext_mask_q, ext_mask_d;

    logic full, empty, merge, ldu_ack, stu_ack, alloc, pop;

    assign full  = count_q == CNT_W'(DEPTH);
    assign empty = count_q == '0;

`ifdef STORE_BUFFER_MERGE_EN
    logic [PTR_W-1:0] tail_prev;
    assign tail_prev = tail_q - PTR_W'(1);
    // The head entry is frozen once its drain request is outstanding.
    assign merge = stu_push_i && !ldu_push_i && !empty && entries_q[tail_prev].valid
                && word_match(entries_q[tail_prev].address, stu_address_i)
                && !(state_q == REQUEST && tail_prev == head_q);
`else
    assign merge = 1'b0;
`endif

    assign ldu_ack = ldu_push_i && !full;
    assign stu_ack = stu_push_i && !ldu_push_i && (!full || merge);
    assign alloc   = ldu_ack || (stu_ack && !merge);
    assign pop     = (state_q == REQUEST) && external_acknowledge_i;

    always_comb begin
        entries_d  = entries_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        state_d    = state_q;
        ext_addr_d = ext_addr_q;
        ext_data_d = ext_data_q;
        ext_mask_d = ext_mask_q;

        if (pop) begin
            entries_d[head_q].valid = 1'b0;
            head_d = head_q + PTR_W'(1);
        end
`ifdef STORE_BUFFER_MERGE_EN
        if (merge) begin
            entries_d[tail_prev].data      = merge_bytes(entries_q[tail_prev].data, stu_data_i, stu_byte_mask_i);
            entries_d[tail_prev].byte_mask = entries_q[tail_prev].byte_mask | stu_byte_mask_i;
        end
`endif
        if (alloc) begin
            entries_d[tail_q].valid     = 1'b1;
            entries_d[tail_q].address   = ldu_ack ? ldu_address_i : stu_address_i;
            entries_d[tail_q].data      = ldu_ack ? ldu_data_i : stu_data_i;
            entries_d[tail_q].byte_mask = ldu_ack ? '1 : stu_byte_mask_i;
            tail_d = tail_q + PTR_W'(1);
        end

        if (alloc && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !alloc) count_d = count_q - CNT_W'(1);

        // Capture from the next-state head so a same-cycle merge is not lost.
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d    = REQUEST;
                    ext_addr_d = entries_d[head_q].address & ~ADDR_WIDTH'(3);
                    ext_data_d = entries_d[head_q].data;
                    ext_mask_d = entries_d[head_q].byte_mask;
                end
            end
            REQUEST: begin
                if (external_acknowledge_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            ext_addr_q <= '0;
            ext_data_q <= '0;
            ext_mask_q <= '0;
        end else begin
            entries_q  <= entries_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            state_q    <= state_d;
            ext_addr_q <= ext_addr_d;
            ext_data_q <= ext_data_d;
            ext_mask_q <= ext_mask_d;
        end
    end

    store_buffer_forward_unit #(.DEPTH(DEPTH)) u_forward (
        .entries_i       (entries_q),
        .head_i          (head_q),
        .load_address_i  (load_address_i),
        .address_match_o (address_match_o),
        .partial_match_o (partial_match_o),
        .data_o          (data_o)
    );

    assign ldu_push_ack_o           = ldu_ack;
    assign stu_push_ack_o           = stu_ack;
    assign full_o                   = full;
    assign empty_o                  = empty;
    assign port_idle_o              = !(ldu_ack || stu_ack);
    assign external_write_request_o = state_q == REQUEST;
    assign external_address_o       = ext_addr_q;
    assign external_data_o          = ext_data_q;
    assign external_byte_mask_o     = ext_mask_q;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_store_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        ldu_push_i, stu_push_i, external_acknowledge_i;
    logic [31:0] ldu_address_i, ldu_data_i, stu_address_i, stu_data_i, load_address_i;
    logic [3:0]  stu_byte_mask_i;
    logic        ldu_push_ack_o, stu_push_ack_o, full_o, empty_o, port_idle_o;
    logic        address_match_o, partial_match_o, external_write_request_o;
    logic [31:0] data_o, external_address_o, external_data_o;
    logic [3:0]  external_byte_mask_o;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } ment_t;

    ment_t model_q[$];
    ment_t drained[$];

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i                    (clk),
        .rst_i                    (rst_i),
        .ldu_push_i               (ldu_push_i),
        .ldu_address_i            (ldu_address_i),
        .ldu_data_i               (ldu_data_i),
        .ldu_push_ack_o           (ldu_push_ack_o),
        .stu_push_i               (stu_push_i),
        .stu_address_i            (stu_address_i),
        .stu_data_i               (stu_data_i),
        .stu_byte_mask_i          (stu_byte_mask_i),
        .stu_push_ack_o           (stu_push_ack_o),
        .full_o                   (full_o),
        .empty_o                  (empty_o),
        .port_idle_o              (port_idle_o),
        .load_address_i           (load_address_i),
        .address_match_o          (address_match_o),
        .partial_match_o          (partial_match_o),
        .data_o                   (data_o),
        .external_write_request_o (external_write_request_o),
        .external_address_o       (external_address_o),
        .external_data_o          (external_data_o),
        .external_byte_mask_o     (external_byte_mask_o),
        .external_acknowledge_i   (external_acknowledge_i)
    );

    task automatic clear_inputs();
        ldu_push_i = 1'b0; ldu_address_i = '0; ldu_data_i = '0;
        stu_push_i = 1'b0; stu_address_i = '0; stu_data_i = '0; stu_byte_mask_i = '0;
        external_acknowledge_i = 1'b0;
    endtask

    task automatic drive_stu(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        stu_push_i = 1'b1; stu_address_i = a; stu_data_i = d; stu_byte_mask_i = m;
    endtask

    // Acknowledges every drain request until the buffer is empty, recording each write.
    task automatic drain_collect(input int max_cycles);
        bit done = 0;
        drained.delete();
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            external_acknowledge_i = 1'b0;
            #1;
            if (empty_o && !external_write_request_o) begin
                done = 1;
                break;
            end
            if (external_write_request_o) begin
                drained.push_back('{a: external_address_o, d: external_data_o, m: external_byte_mask_o});
                external_acknowledge_i = 1'b1;
            end
        end
        external_acknowledge_i = 1'b0;
        compared++;
        if (!done) begin
            mismatched++;
            $display("FAIL drain_timeout: buffer still busy after %0d cycles", max_cycles);
        end
    endtask

    // Reference forwarding: youngest queued word match decides the result.
    function automatic void fwd_model(input logic [31:0] la, output logic am, output logic pm,
                                      output logic [31:0] d);
        am = 0; pm = 0; d = '0;
        for (int i = model_q.size() - 1; i >= 0; i--) begin
            if (model_q[i].a[31:2] == la[31:2]) begin
                if (model_q[i].m == 4'hF) begin am = 1; d = model_q[i].d; end
                else pm = 1;
                break;
            end
        end
    endfunction

    task automatic test_reset();
        rst_i = 1'b1;
        clear_inputs();
        load_address_i = '0;
        repeat (2) @(negedge clk);
        #1;
        compared++;
        if ({empty_o, port_idle_o, full_o, ldu_push_ack_o, stu_push_ack_o} !== 5'b11000) begin
            mismatched++;
            $display("FAIL reset_status: got %b expected 11000", {empty_o, port_idle_o, full_o, ldu_push_ack_o, stu_push_ack_o});
        end
        compared++;
        if ({address_match_o, partial_match_o, data_o} !== 34'h0) begin
            mismatched++;
            $display("FAIL reset_forward: got %b %b %h expected 0 0 0", address_match_o, partial_match_o, data_o);
        end
        compared++;
        if ({external_write_request_o, external_address_o, external_data_o, external_byte_mask_o} !== 69'h0) begin
            mismatched++;
            $display("FAIL reset_external: got req %b addr %h data %h mask %h expected all 0",
                     external_write_request_o, external_address_o, external_data_o, external_byte_mask_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic test_single();
        bit found = 0;
        @(negedge clk);
        drive_stu(32'h1000, 32'hDEADBEEF, 4'hF);
        #1;
        compared++;
        if (stu_push_ack_o !== 1'b1 || port_idle_o !== 1'b0) begin
            mismatched++;
            $display("FAIL single_ack: got ack %b idle %b expected 1 0", stu_push_ack_o, port_idle_o);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        compared++;
        if (empty_o !== 1'b0) begin
            mismatched++;
            $display("FAIL single_empty: got %b expected 0", empty_o);
        end
        for (int c = 0; c < 10; c++) begin
            if (external_write_request_o) begin found = 1; break; end
            @(negedge clk);
            #1;
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("FAIL single_request: got request 0 expected 1");
        end
        compared++;
        if (external_address_o !== 32'h1000 || external_data_o !== 32'hDEADBEEF || external_byte_mask_o !== 4'hF) begin
            mismatched++;
            $display("FAIL single_payload: got %h %h %h expected 00001000 deadbeef f",
                     external_address_o, external_data_o, external_byte_mask_o);
        end
        external_acknowledge_i = 1'b1;
        @(negedge clk);
        external_acknowledge_i = 1'b0;
        #1;
        compared++;
        if (empty_o !== 1'b1 || external_write_request_o !== 1'b0) begin
            mismatched++;
            $display("FAIL single_drained: got empty %b req %b expected 1 0", empty_o, external_write_request_o);
        end
    endtask

    task automatic test_full();
        bit found = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            drive_stu(32'h5000 + 32'(i) * 4, $urandom, 4'hF);
            #1;
            compared++;
            if (stu_push_ack_o !== 1'b1) begin
                mismatched++;
                $display("FAIL full_fill_ack%0d: got %b expected 1", i, stu_push_ack_o);
            end
        end
        @(negedge clk);
        drive_stu(32'h5100, 32'h99999999, 4'hF);
        #1;
        compared++;
        if (full_o !== 1'b1 || stu_push_ack_o !== 1'b0 || port_idle_o !== 1'b1) begin
            mismatched++;
            $display("FAIL full_block: got full %b ack %b idle %b expected 1 0 1", full_o, stu_push_ack_o, port_idle_o);
        end
        for (int c = 0; c < 10; c++) begin
            if (external_write_request_o) begin found = 1; break; end
            @(negedge clk);
            #1;
        end
        external_acknowledge_i = 1'b1;
        #1;
        compared++;
        if (!found || stu_push_ack_o !== 1'b0) begin
            mismatched++;
            $display("FAIL full_same_cycle_pop: got req %b ack %b expected 1 0", found, stu_push_ack_o);
        end
        @(negedge clk);
        external_acknowledge_i = 1'b0;
        #1;
        compared++;
        if (full_o !== 1'b0 || stu_push_ack_o !== 1'b1) begin
            mismatched++;
            $display("FAIL full_freed: got full %b ack %b expected 0 1", full_o, stu_push_ack_o);
        end
        @(negedge clk);
        clear_inputs();
        drain_collect(200);
        compared++;
        if (drained.size() != DEPTH) begin
            mismatched++;
            $display("FAIL full_drain_count: got %0d expected %0d", drained.size(), DEPTH);
        end else begin
            compared++;
            if (drained[0].a !== 32'h5004 || drained[DEPTH-1].a !== 32'h5100 || drained[DEPTH-1].d !== 32'h99999999) begin
                mismatched++;
                $display("FAIL full_drain_order: got first %h last %h/%h expected 00005004 00005100/99999999",
                         drained[0].a, drained[DEPTH-1].a, drained[DEPTH-1].d);
            end
        end
    endtask

    task automatic test_priority();
        @(negedge clk);
        ldu_push_i = 1'b1; ldu_address_i = 32'h6000; ldu_data_i = 32'hA5A5A5A5;
        drive_stu(32'h6004, 32'h5A5A5A5A, 4'h3);
        #1;
        compared++;
        if (ldu_push_ack_o !== 1'b1 || stu_push_ack_o !== 1'b0) begin
            mismatched++;
            $display("FAIL prio_both: got ldu %b stu %b expected 1 0", ldu_push_ack_o, stu_push_ack_o);
        end
        @(negedge clk);
        ldu_push_i = 1'b0;
        #1;
        compared++;
        if (stu_push_ack_o !== 1'b1) begin
            mismatched++;
            $display("FAIL prio_stu_next: got %b expected 1", stu_push_ack_o);
        end
        @(negedge clk);
        clear_inputs();
        drain_collect(100);
        compared++;
        if (drained.size() != 2) begin
            mismatched++;
            $display("FAIL prio_drain_count: got %0d expected 2", drained.size());
        end else begin
            compared++;
            if (drained[0].a !== 32'h6000 || drained[0].m !== 4'hF || drained[1].a !== 32'h6004 || drained[1].m !== 4'h3) begin
                mismatched++;
                $display("FAIL prio_drain_order: got %h/%h %h/%h expected 00006000/f 00006004/3",
                         drained[0].a, drained[0].m, drained[1].a, drained[1].m);
            end
        end
    endtask

    task automatic test_forward();
        @(negedge clk);
        load_address_i = 32'h2002;
        drive_stu(32'h2000, 32'h11111111, 4'hF);
        #1;
        compared++;
        if (address_match_o !== 1'b0 || partial_match_o !== 1'b0) begin
            mismatched++;
            $display("FAIL fwd_same_cycle: got %b %b expected 0 0", address_match_o, partial_match_o);
        end
        @(negedge clk);
        drive_stu(32'h2000, 32'h22222222, 4'hF);
        #1;
        compared++;
        if (address_match_o !== 1'b1 || data_o !== 32'h11111111) begin
            mismatched++;
            $display("FAIL fwd_first: got %b %h expected 1 11111111", address_match_o, data_o);
        end
        @(negedge clk);
        drive_stu(32'h2000, 32'h33333333, 4'h3);
        #1;
        compared++;
        if (address_match_o !== 1'b1 || partial_match_o !== 1'b0 || data_o !== 32'h22222222) begin
            mismatched++;
            $display("FAIL fwd_youngest: got %b %b %h expected 1 0 22222222", address_match_o, partial_match_o, data_o);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        compared++;
        if (address_match_o !== 1'b0 || partial_match_o !== 1'b1 || data_o !== 32'h0) begin
            mismatched++;
            $display("FAIL fwd_partial: got %b %b %h expected 0 1 0", address_match_o, partial_match_o, data_o);
        end
        load_address_i = 32'h2F00;
        #1;
        compared++;
        if (address_match_o !== 1'b0 || partial_match_o !== 1'b0 || data_o !== 32'h0) begin
            mismatched++;
            $display("FAIL fwd_miss: got %b %b %h expected 0 0 0", address_match_o, partial_match_o, data_o);
        end
        drain_collect(100);
        compared++;
`ifdef STORE_BUFFER_MERGE_EN
        if (drained.size() != 2) begin
            mismatched++;
            $display("FAIL fwd_drain_count: got %0d expected 2", drained.size());
        end
`else
        if (drained.size() != 3) begin
            mismatched++;
            $display("FAIL fwd_drain_count: got %0d expected 3", drained.size());
        end
`endif
    endtask

    task automatic test_merge();
        @(negedge clk);
        drive_stu(32'h3000, 32'h000000AA, 4'h1);
        #1;
        compared++;
        if (stu_push_ack_o !== 1'b1) begin
            mismatched++;
            $display("FAIL merge_ack0: got %b expected 1", stu_push_ack_o);
        end
        @(negedge clk);
        drive_stu(32'h3000, 32'h0000BB00, 4'h2);
        #1;
        compared++;
        if (stu_push_ack_o !== 1'b1) begin
            mismatched++;
            $display("FAIL merge_ack1: got %b expected 1", stu_push_ack_o);
        end
        @(negedge clk);
        clear_inputs();
        drain_collect(100);
`ifdef STORE_BUFFER_MERGE_EN
        compared++;
        if (drained.size() != 1) begin
            mismatched++;
            $display("FAIL merge_count: got %0d expected 1", drained.size());
        end else begin
            compared++;
            if (drained[0].d !== 32'h0000BBAA || drained[0].m !== 4'h3) begin
                mismatched++;
                $display("FAIL merge_payload: got %h/%h expected 0000bbaa/3", drained[0].d, drained[0].m);
            end
        end
`else
        compared++;
        if (drained.size() != 2) begin
            mismatched++;
            $display("FAIL merge_count: got %0d expected 2", drained.size());
        end else begin
            compared++;
            if (drained[0].d !== 32'h000000AA || drained[0].m !== 4'h1 || drained[1].d !== 32'h0000BB00 || drained[1].m !== 4'h2) begin
                mismatched++;
                $display("FAIL merge_payload: got %h/%h %h/%h expected 000000aa/1 0000bb00/2",
                         drained[0].d, drained[0].m, drained[1].d, drained[1].m);
            end
        end
`endif
    endtask

    // Random traffic across many pointer wraps; stu words are unique so no merge occurs,
    // while ldu words repeat to exercise youngest-entry forwarding.
    task automatic test_wrap_random();
        bit          ldu_pend = 0, stu_pend = 0, ack_now;
        logic [31:0] ldu_a = '0, ldu_d = '0, stu_a = '0, stu_d = '0, exp_d;
        logic [3:0]  stu_m = '0;
        logic        exp_full, exp_lack, exp_sack, exp_am, exp_pm;
        int          stu_seq = 0, pushes = 0;
        model_q.delete();
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (!ldu_pend && $urandom_range(0, 3) == 0) begin
                ldu_pend = 1;
                ldu_a = 32'h8000_0000 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
                ldu_d = $urandom;
            end
            if (!stu_pend && $urandom_range(0, 1) == 0) begin
                stu_pend = 1;
                stu_seq++;
                stu_a = 32'h4000_0000 + 32'(stu_seq) * 4 + 32'($urandom_range(0, 3));
                stu_d = $urandom;
                stu_m = 4'($urandom_range(1, 15));
            end
            ldu_push_i = ldu_pend; ldu_address_i = ldu_a; ldu_data_i = ldu_d;
            stu_push_i = stu_pend; stu_address_i = stu_a; stu_data_i = stu_d; stu_byte_mask_i = stu_m;
            case ($urandom_range(0, 3))
                0:       load_address_i = 32'h8000_0000 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
                1:       load_address_i = 32'h4000_0000 + 32'(stu_seq - $urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
                2:       load_address_i = 32'h7000_0000;
                default: load_address_i = stu_a;
            endcase
            ack_now = external_write_request_o && ($urandom_range(0, 2) != 0);
            external_acknowledge_i = ack_now;
            #1;
            exp_full = model_q.size() == DEPTH;
            exp_lack = ldu_pend && !exp_full;
            exp_sack = stu_pend && !ldu_pend && !exp_full;
            compared++;
            if ({ldu_push_ack_o, stu_push_ack_o, full_o, empty_o} !== {exp_lack, exp_sack, exp_full, model_q.size() == 0}) begin
                mismatched++;
                $display("FAIL rnd_status cyc %0d: got %b expected %b", cyc,
                         {ldu_push_ack_o, stu_push_ack_o, full_o, empty_o}, {exp_lack, exp_sack, exp_full, model_q.size() == 0});
            end
            fwd_model(load_address_i, exp_am, exp_pm, exp_d);
            compared++;
            if (address_match_o !== exp_am || partial_match_o !== exp_pm || data_o !== exp_d) begin
                mismatched++;
                $display("FAIL rnd_forward cyc %0d addr %h: got %b %b %h expected %b %b %h", cyc, load_address_i,
                         address_match_o, partial_match_o, data_o, exp_am, exp_pm, exp_d);
            end
            if (external_write_request_o) begin
                compared++;
                if (model_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL rnd_spurious_request cyc %0d: got request with empty model", cyc);
                end else if (external_address_o !== model_q[0].a || external_data_o !== model_q[0].d
                             || external_byte_mask_o !== model_q[0].m) begin
                    mismatched++;
                    $display("FAIL rnd_head cyc %0d: got %h/%h/%h expected %h/%h/%h", cyc, external_address_o,
                             external_data_o, external_byte_mask_o, model_q[0].a, model_q[0].d, model_q[0].m);
                end
            end
            if (exp_lack) begin
                model_q.push_back('{a: ldu_a & ~32'h3, d: ldu_d, m: 4'hF});
                ldu_pend = 0;
                pushes++;
            end
            if (exp_sack) begin
                model_q.push_back('{a: stu_a & ~32'h3, d: stu_d, m: stu_m});
                stu_pend = 0;
                pushes++;
            end
            if (ack_now && model_q.size() > 0) void'(model_q.pop_front());
        end
        @(negedge clk);
        clear_inputs();
        drain_collect(400);
        compared++;
        if (drained.size() != model_q.size()) begin
            mismatched++;
            $display("FAIL rnd_tail_count: got %0d expected %0d (pushes %0d)", drained.size(), model_q.size(), pushes);
        end else begin
            foreach (drained[i]) begin
                compared++;
                if (drained[i].a !== model_q[i].a || drained[i].d !== model_q[i].d || drained[i].m !== model_q[i].m) begin
                    mismatched++;
                    $display("FAIL rnd_tail_order %0d: got %h/%h/%h expected %h/%h/%h", i, drained[i].a,
                             drained[i].d, drained[i].m, model_q[i].a, model_q[i].d, model_q[i].m);
                end
            end
        end
        model_q.delete();
        #1;
        compared++;
        if (empty_o !== 1'b1 || full_o !== 1'b0) begin
            mismatched++;
            $display("FAIL rnd_final_empty: got empty %b full %b expected 1 0", empty_o, full_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_priority();
        test_forward();
        test_merge();
        test_wrap_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits between the data cache controllers and external memory.
- Queues stores from the store unit, and dirty-line writebacks from the load unit, in a FIFO.
- Drains entries to external memory with a request/acknowledge handshake.
- Forwards buffered data to the load unit controller when a load hits a pending word.

Parameters:
- DEPTH, 8, number of entries; power of two, ≥2.
- ADDR_WIDTH, 32, byte address width; bits [1:0] are ignored for matching.
- PORT_WIDTH, 32, data word width; PORT_BYTES = PORT_WIDTH/8.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- ldu_push_i  in  1  load unit writeback push request
- ldu_address_i  in  ADDR_WIDTH  writeback word address
- ldu_data_i  in  PORT_WIDTH  writeback word; byte mask is implicitly all ones
- ldu_push_ack_o  out  1  writeback accepted this cycle
- stu_push_i  in  1  store unit push request
- stu_address_i  in  ADDR_WIDTH  store address
- stu_data_i  in  PORT_WIDTH  store data, byte lanes aligned
- stu_byte_mask_i  in  PORT_BYTES  store byte enables
- stu_push_ack_o  out  1  store accepted this cycle
- full_o  out  1  count == DEPTH
- empty_o  out  1  count == 0
- port_idle_o  out  1  no push accepted this cycle
- load_address_i  in  ADDR_WIDTH  forwarding lookup address
- address_match_o  out  1  youngest matching entry has a full mask
- partial_match_o  out  1  youngest matching entry has a partial mask; the load must wait
- data_o  out  PORT_WIDTH  forwarded word
- external_write_request_o  out  1  drain request
- external_address_o  out  ADDR_WIDTH  head address, bits [1:0] = 0
- external_data_o  out  PORT_WIDTH  head data
- external_byte_mask_o  out  PORT_BYTES  head mask
- external_acknowledge_i  in  1  memory accepted the head entry

Behaviour:
- Reset: pointers and count = 0, all valid bits = 0, drain FSM in IDLE.
  - Outputs at reset: empty_o = 1, port_idle_o = 1; every other output = 0.
- Push arbitration: ldu has priority.
  - ldu_push_ack_o = ldu_push_i & ~full_o.
  - stu_push_ack_o = stu_push_i & ~ldu_push_i & ~full_o.
  - Both acks are combinational. A requester holds its request until acked.
- On an ack, the entry is written at the tail on the next rising edge and the tail advances, wrapping at DEPTH.
- Full: no ack is given. A same-cycle pop does not free a slot for a same-cycle push.
- Drain FSM, IDLE → REQUEST → IDLE:
  - IDLE: moves to REQUEST when ~empty.
  - REQUEST: holds external_write_request_o = 1, with address/data/mask registered from the head and stable, until external_acknowledge_i.
  - Ack: head invalidated, head pointer advances; FSM returns to IDLE, giving 1 idle cycle between drains.
  - Acknowledge while in IDLE is ignored.
- Push and pop in the same cycle: count unchanged. Pointers wrap independently. Count width is clog2(DEPTH)+1.
- Forwarding is combinational:
  - Word-address compare of load_address_i against all valid entries, including the head entry while in REQUEST.
  - Priority goes to the youngest entry (nearest tail).
  - A full mask gives address_match_o = 1 and data_o = entry data.
  - Any other mask gives partial_match_o = 1 and data_o = 0.
  - No match gives both flags = 0 and data_o = 0.
  - An entry pushed this cycle is not visible until the next cycle.
- Reset mid-drain: the request drops immediately and all entries are lost. Software/system is responsible.

Optional Feature:
- STORE_BUFFER_MERGE_EN defined:
  - A stu push whose word address equals the youngest valid entry, which is not head-in-REQUEST, merges into that entry byte-wise: the mask is ORed and the new bytes overwrite.
  - The push is acked, with no allocation and no count change. Merging is allowed even when full.
  - Ldu pushes never merge.
- Undefined: every accepted push allocates a new entry.

Decomposition:
- Shared package:
  - store_buffer_entry_t {valid, address, data, byte_mask}
  - store_buffer_state_t {IDLE, REQUEST}
  - PORT_BYTES
- Sub-module store_buffer_forward_unit: the combinational youngest-match search over the entry array, given the head/tail pointers.

Test Plan:
- Reset, then stu push of 0x1000/0xDEADBEEF/mask 4'b1111 → next cycle empty_o = 0; request = 1 with address 0x1000, data 0xDEADBEEF; ack → empty_o = 1 one cycle later.
- 8 stu pushes with no acks → full_o = 1, 9th push gets stu_push_ack_o = 0; one ack → full_o = 0 next cycle, 9th push accepted.
- ldu_push_i and stu_push_i asserted together, not full → ldu_push_ack_o = 1, stu_push_ack_o = 0; stu acked the following cycle.
- Pushes to 0x2000 with 0x11111111 then 0x22222222 (both full mask); load_address_i = 0x2002 → address_match_o = 1, data_o = 0x22222222. Mask 4'b0011 instead → partial_match_o = 1.
- Fill and drain 20 entries across the pointer wrap → external writes appear in push order, count returns to 0.
- With STORE_BUFFER_MERGE_EN: push 0x3000 mask 0001 data 0xAA, then mask 0010 data 0xBB00 before drain → a single drain with data 0xBBAA, mask 0011. Without the macro → two drains.
